// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file types shared by the writeback scheduler
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t   rd;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wbsched_arbiter.sv
// rtl/wbsched_arbiter.sv - writeback requester arbiter (round-robin when WBSCHED_RR_EN is defined, else fixed priority)
module wbsched_arbiter #(
  parameter int NREQ = 2
) (
`ifdef WBSCHED_RR_EN
  input  logic            clk,
  input  logic            rst,
`endif
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt
);

`ifdef WBSCHED_RR_EN
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_next_ptr;
  logic             w_found;

  // Search from r_rr_ptr upward with wrap; the first requester found wins.
  always_comb begin
    int idx;
    o_gnt      = '0;
    w_found    = 1'b0;
    w_next_ptr = r_rr_ptr;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        w_found    = 1'b1;
        w_next_ptr = (idx + 1 == NREQ) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  // Pointer moves just past the winner; it holds when nobody asked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_found) begin
      r_rr_ptr <= w_next_ptr;
    end
  end
`else
  logic w_found;

  // Lowest-indexed requester wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_gnt[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - register file write-port scheduler and hazard scoreboard (option macro: WBSCHED_RR_EN)
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid_i,
  input  logic                   issue_wr_i,
  input  logic [4:0]             issue_rd_i,
  input  logic [4:0]             issue_rs1_i,
  input  logic [4:0]             issue_rs2_i,
  output logic                   issue_stall_o,
  input  logic [NREQ-1:0]        wb_valid_i,
  input  logic [NREQ*5-1:0]      wb_rd_i,
  input  logic [NREQ*DWIDTH-1:0] wb_data_i,
  output logic [NREQ-1:0]        wb_ready_o,
  output logic [4:0]             rf_rd_o,
  output logic [DWIDTH-1:0]      rf_data_o,
  output logic                   rf_wren_o,
  output logic [31:0]            busy_o,
  output logic                   err_o
);

  // x0 never has a pending writer, so only bits 31..1 are stored.
  logic [NUM_REGS-1:1] r_busy;
  logic                r_err;

  logic [NUM_REGS-1:0] w_busy;
  logic [NREQ-1:0]     w_arb_gnt;
  logic [NREQ-1:0]     w_gnt;
  logic                w_any;
  reg_addr_t           w_rd;
  logic [DWIDTH-1:0]   w_data;
  logic                w_accept;
  logic                w_set;

  assign w_busy = {r_busy, 1'b0};

  wbsched_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
`ifdef WBSCHED_RR_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .i_req (wb_valid_i),
    .o_gnt (w_arb_gnt)
  );

  // No writeback is accepted while reset is held.
  assign w_gnt = w_arb_gnt & {NREQ{~rst}};

  // Steer the granted requester onto the write port; idle port reads as all zero.
  always_comb begin
    w_any  = 1'b0;
    w_rd   = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_any  = 1'b1;
        w_rd   = wb_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
        w_data = wb_data_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign wb_ready_o = w_gnt;
  assign rf_rd_o    = w_rd;
  assign rf_data_o  = w_data;
  assign rf_wren_o  = w_any && (w_rd != '0);

  // Stall looks only at registered busy bits, so a same-cycle clear still stalls.
  assign issue_stall_o = rst ||
                         (issue_valid_i && (w_busy[issue_rs1_i] || w_busy[issue_rs2_i] ||
                                            (issue_wr_i && w_busy[issue_rd_i])));
  assign w_accept = issue_valid_i && !issue_stall_o;
  assign w_set    = w_accept && issue_wr_i;

  // Scoreboard: a new producer setting a bit wins over a writeback clearing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_set && (issue_rd_i == REG_ADDR_W'(r))) begin
          r_busy[r] <= 1'b1;
        end else if (rf_wren_o && (rf_rd_o == REG_ADDR_W'(r))) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  // Sticky flag for a writeback to a register nobody was waiting on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (rf_wren_o && !w_busy[w_rd]) begin
      r_err <= 1'b1;
    end
  end

  assign busy_o = w_busy;
  assign err_o  = r_err;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed vector bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        issue_valid_i;
  logic        issue_wr_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  issue_rs1_i;
  logic [4:0]  issue_rs2_i;
  logic        issue_stall_o;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_rd_i;
  logic [63:0] wb_data_i;
  logic [1:0]  wb_ready_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic        rf_wren_o;
  logic [31:0] busy_o;
  logic        err_o;

  int n_vec;
  int n_bad;

  regfile_wb_scheduler #(
    .NREQ   (2),
    .DWIDTH (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_wr_i    (issue_wr_i),
    .issue_rd_i    (issue_rd_i),
    .issue_rs1_i   (issue_rs1_i),
    .issue_rs2_i   (issue_rs2_i),
    .issue_stall_o (issue_stall_o),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .wb_ready_o    (wb_ready_o),
    .rf_rd_o       (rf_rd_o),
    .rf_data_o     (rf_data_o),
    .rf_wren_o     (rf_wren_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        iw;
    logic [4:0]  ird;
    logic [4:0]  irs1;
    logic [4:0]  irs2;
    logic [1:0]  wv;
    logic [4:0]  wrd0;
    logic [4:0]  wrd1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        e_stall;
    logic [1:0]  e_ready;
    logic        e_wren;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    issue_wr_i    = 1'b0;
    issue_rd_i    = 5'd0;
    issue_rs1_i   = 5'd0;
    issue_rs2_i   = 5'd0;
    wb_valid_i    = 2'b00;
    wb_rd_i       = 10'd0;
    wb_data_i     = 64'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    //            iv    iw    ird    rs1    rs2    wv     wrd0   wrd1   wd0            wd1            stall ready  wren  rd     data           busy           err
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 5'd1, 5'd2, 2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 2'b00, 1'b0, 5'd0, 32'h0,         32'h0000_0020, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b1, 2'b00, 1'b0, 5'd0, 32'h0,         32'h0000_0020, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 2'b01, 5'd5, 5'd0, 32'h1111_1111, 32'h0,         1'b1, 2'b01, 1'b1, 5'd5, 32'h1111_1111, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 2'b00, 1'b0, 5'd0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 2'b00, 1'b0, 5'd0, 32'h0,         32'h0000_0080, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 5'd0, 5'd0, 32'h0,         32'hDEAD_BEEF, 1'b0, 2'b10, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0000_0080, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h0000_0007, 32'h0,         1'b1, 2'b01, 1'b1, 5'd7, 32'h0000_0007, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 2'b00, 1'b0, 5'd0, 32'h0,         32'h0000_0080, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 5'd0, 5'd7, 32'h0,         32'h0000_0077, 1'b0, 2'b10, 1'b1, 5'd7, 32'h0000_0077, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 32'hAAAA_0007, 32'h0,         1'b0, 2'b01, 1'b1, 5'd7, 32'hAAAA_0007, 32'h0000_0080, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,         32'h0,         1'b0, 2'b00, 1'b0, 5'd0, 32'h0,         32'h0000_0080, 1'b1};

    // Reset behaviour, with a writeback and an issue pending during reset.
    rst = 1'b1;
    idle();
    wb_valid_i    = 2'b11;
    wb_rd_i       = {5'd4, 5'd3};
    issue_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {30'd0, wb_ready_o}, 32'd0);
    chk("rst_wren",  {31'd0, rf_wren_o},  32'd0);
    chk("rst_stall", {31'd0, issue_stall_o}, 32'd1);
    chk("rst_busy",  busy_o, 32'd0);
    chk("rst_err",   {31'd0, err_o}, 32'd0);
    rst = 1'b0;
    idle();

    // Table of single-cycle vectors; combinational outputs checked before the edge, state after.
    for (int v = 0; v < 11; v++) begin
      issue_valid_i = vecs[v].iv;
      issue_wr_i    = vecs[v].iw;
      issue_rd_i    = vecs[v].ird;
      issue_rs1_i   = vecs[v].irs1;
      issue_rs2_i   = vecs[v].irs2;
      wb_valid_i    = vecs[v].wv;
      wb_rd_i       = {vecs[v].wrd1, vecs[v].wrd0};
      wb_data_i     = {vecs[v].wd1, vecs[v].wd0};
      #3;
      chk($sformatf("v%0d_stall", v), {31'd0, issue_stall_o}, {31'd0, vecs[v].e_stall});
      chk($sformatf("v%0d_ready", v), {30'd0, wb_ready_o},    {30'd0, vecs[v].e_ready});
      chk($sformatf("v%0d_wren", v),  {31'd0, rf_wren_o},     {31'd0, vecs[v].e_wren});
      chk($sformatf("v%0d_rd", v),    {27'd0, rf_rd_o},       {27'd0, vecs[v].e_rd});
      chk($sformatf("v%0d_data", v),  rf_data_o,              vecs[v].e_data);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", v),  busy_o,                 vecs[v].e_busy);
      chk($sformatf("v%0d_err", v),   {31'd0, err_o},         {31'd0, vecs[v].e_err});
    end

    // Arbitration with both requesters held valid for four cycles.
    do_reset();
    begin
      logic [1:0] exp_g[4];
`ifdef WBSCHED_RR_EN
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      wb_valid_i = 2'b11;
      wb_rd_i    = {5'd2, 5'd1};
      wb_data_i  = {32'h2222_2222, 32'h1111_1111};
      for (int c = 0; c < 4; c++) begin
        #3;
        chk($sformatf("arb_c%0d", c), {30'd0, wb_ready_o}, {30'd0, exp_g[c]});
        chk($sformatf("arb_rd_c%0d", c), {27'd0, rf_rd_o}, exp_g[c] == 2'b01 ? 32'd1 : 32'd2);
        @(posedge clk);
        #1;
      end
      idle();
    end

    // Stray writeback sets a sticky error that only reset clears.
    do_reset();
    chk("err_init", {31'd0, err_o}, 32'd0);
    wb_valid_i = 2'b01;
    wb_rd_i    = {5'd0, 5'd9};
    wb_data_i  = {32'h0, 32'h0000_0099};
    #3;
    chk("err_wren", {31'd0, rf_wren_o}, 32'd1);
    @(posedge clk);
    #1;
    idle();
    chk("err_set", {31'd0, err_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, err_o}, 32'd0);

    // Reset asserted mid-stream with four registers pending and a writeback waiting.
    for (int r = 8; r < 12; r++) begin
      issue_valid_i = 1'b1;
      issue_wr_i    = 1'b1;
      issue_rd_i    = 5'(r);
      @(posedge clk);
      #1;
    end
    idle();
    chk("mid_busy", busy_o, 32'h0000_0F00);
    rst           = 1'b1;
    wb_valid_i    = 2'b01;
    wb_rd_i       = {5'd0, 5'd8};
    wb_data_i     = {32'h0, 32'h0000_0088};
    issue_valid_i = 1'b1;
    issue_wr_i    = 1'b1;
    issue_rd_i    = 5'd12;
    #3;
    chk("mid_ready", {30'd0, wb_ready_o}, 32'd0);
    chk("mid_wren",  {31'd0, rf_wren_o},  32'd0);
    chk("mid_stall", {31'd0, issue_stall_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    chk("post_busy", busy_o, 32'd0);
    chk("post_err",  {31'd0, err_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
